// File: rtl/hazard_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
package hazard_pkg;

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_WAW  = 2'd1;
  localparam logic [1:0] STALL_RAW  = 2'd2;

  // Entry field widths; the top-level LAT_W / FLUSH_AGE defaults track these.
  localparam int SB_LAT_W     = 4;
  localparam int SB_FLUSH_AGE = 1;
  localparam int SB_AGE_W     = $clog2(SB_FLUSH_AGE + 1);

  typedef struct packed {
    logic                pending;
    logic [SB_LAT_W-1:0] rem;
    logic [SB_AGE_W-1:0] age;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight write tracker: load on issue,
// count rem down / age up while pending, clear on writeback or young flush.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int FLUSH_AGE = SB_FLUSH_AGE
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load_i,
  input  logic [SB_LAT_W-1:0] load_rem_i,
  input  logic                wb_clr_i,
  input  logic                flush_i,
  output logic                pending_o,
  output logic [SB_LAT_W-1:0] rem_o
);

  sb_entry_t q;
  logic      young;

  assign young     = int'(q.age) < FLUSH_AGE;
  assign pending_o = q.pending;
  assign rem_o     = q.rem;

  // Issue load beats writeback; otherwise clear, or tick rem/age with saturation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (load_i) begin
      q.pending <= 1'b1;
      q.rem     <= load_rem_i;
      q.age     <= '0;
    end else if (q.pending) begin
      if (wb_clr_i || (flush_i && young)) begin
        q <= '0;
      end else begin
        if (q.rem != '0) q.rem <= q.rem - 1'b1;
        if (q.age != '1) q.age <= q.age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write tracking with
// RAW/WAW stall decision and per-source bypass hits for the issue stage.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int NSRC      = 2,
  parameter int LAT_W     = SB_LAT_W,
  parameter int FLUSH_AGE = SB_FLUSH_AGE
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid_i,
  input  logic               issue_we_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic [LAT_W-1:0]   issue_lat_i,
  input  logic [NSRC-1:0]    src_valid_i,
  input  logic [NSRC*AW-1:0] src_addr_i,
  input  logic               wb_we_i,
  input  logic [AW-1:0]      wb_rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [1:0]         stall_code_o,
  output logic [NSRC-1:0]    src_bypass_o,
  output logic               busy_o
);

  logic [NREG-1:0]     pend;
  logic [NREG-1:0]     eff_pend;
  logic [NREG-1:0]     rem_zero;
  logic [NREG-1:1]     load;
  logic [NREG-1:1]     wb_clr;
  logic [SB_LAT_W-1:0] rem_q [1:NREG-1];
  logic [LAT_W-1:0]    load_rem;
  logic [NSRC-1:0]     raw;
  logic [AW-1:0]       src_a;
  logic                waw;
  logic                fire;

  assign pend[0] = 1'b0;

  // Write-through register file: a same-cycle writeback already resolves the hazard.
  always_comb begin
    eff_pend = '0;
    rem_zero = '0;
    wb_clr   = '0;
    for (int r = 1; r < NREG; r++) begin
      wb_clr[r]   = wb_we_i && (int'(wb_rd_i) == r);
      eff_pend[r] = pend[r] && !wb_clr[r];
      rem_zero[r] = (rem_q[r] == '0);
    end
  end

  // Per-source comparison: pending with rem left is RAW, rem exhausted is a bypass hit.
  always_comb begin
    raw          = '0;
    src_bypass_o = '0;
    src_a        = '0;
    for (int s = 0; s < NSRC; s++) begin
      src_a = src_addr_i[s*AW +: AW];
      if (src_valid_i[s] && (src_a != '0) && (int'(src_a) < NREG) && eff_pend[src_a]) begin
        if (rem_zero[src_a]) src_bypass_o[s] = 1'b1;
        else                 raw[s]          = 1'b1;
      end
    end
  end

  // Destination check against an outstanding write to the same register.
  always_comb begin
    waw = 1'b0;
    if (issue_we_i && (issue_rd_i != '0) && (int'(issue_rd_i) < NREG))
      waw = eff_pend[issue_rd_i];
  end

  assign stall_o = issue_valid_i && ((|raw) || waw);
  assign fire    = issue_valid_i && !stall_o && !flush_i;
  assign busy_o  = |pend;

  // A latency of 0 behaves like 1, so the loaded countdown is max(lat,1)-1.
  assign load_rem = (issue_lat_i == '0) ? '0 : issue_lat_i - 1'b1;

  // RAW outranks WAW in the reported stall reason.
  always_comb begin
    stall_code_o = STALL_NONE;
    if (issue_valid_i) begin
      if (|raw)    stall_code_o = STALL_RAW;
      else if (waw) stall_code_o = STALL_WAW;
    end
  end

  // Destination decode for the entry load strobe.
  always_comb begin
    load = '0;
    for (int r = 1; r < NREG; r++)
      load[r] = fire && issue_we_i && (int'(issue_rd_i) == r);
  end

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(.FLUSH_AGE(FLUSH_AGE)) u_ent (
      .clk        (clk),
      .resetn     (resetn),
      .load_i     (load[r]),
      .load_rem_i (SB_LAT_W'(load_rem)),
      .wb_clr_i   (wb_clr[r]),
      .flush_i    (flush_i),
      .pending_o  (pend[r]),
      .rem_o      (rem_q[r])
    );
  end

endmodule
